key_debounce_bank: RTL and testbench

//  - N-channel push-button front end: synchronise, debounce, edge-detect and long-press-detect active-low keys.
//  - Drives one toggle LED register per key and exports per-key event pulses for downstream control logic.
//  - Sits between board key pins and the user-logic/LED layer; this block owns all key timing for the design.

---
 rtl/key_pkg.sv | 11 +
 rtl/key_debounce_ch.sv | 121 ++++++++++++
 rtl/key_debounce_bank.sv | 38 +++
 tb/tb_key_debounce_bank.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants for the push-button front end.
package key_pkg;

    // Default timing at a 50 MHz system clock.
    localparam int unsigned DEBOUNCE_20MS_50M = 1_000_000;
    localparam int unsigned LONG_1S_50M       = 50_000_000;

    // Keys are wired active-low: a pressed key pulls its pin to 0.
    localparam logic KEY_PRESSED = 1'b0;

endpackage : key_pkg

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce counter, edge detect, hold counter, LED bit.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_20MS_50M,
    parameter int unsigned LONG_CYC     = LONG_1S_50M,
    parameter logic        LED_INIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic rel_pulse,
    output logic long_pulse,
    output logic led
);

    localparam int unsigned CNT_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned HOLD_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              stable_q, stable_d;
    logic              stable_prev_q, stable_prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              key_level_q, key_level_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;
    logic              long_q, long_d;
    logic              led_q, led_d;

    // Next-state logic for the whole channel.
    always_comb begin
        sync1_d       = key_n;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        long_done_d   = long_done_q;
        key_level_d   = (stable_q == KEY_PRESSED);
        press_d       = (stable_prev_q != KEY_PRESSED) && (stable_q == KEY_PRESSED);
        rel_d         = (stable_prev_q == KEY_PRESSED) && (stable_q != KEY_PRESSED);
        long_d        = 1'b0;
        led_d         = led_q;

        // A new level is accepted only after DEBOUNCE_CYC consecutive differing samples.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Hold counter saturates; the done flag keeps the long event to once per press.
        if (stable_q == KEY_PRESSED) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_W'(1);
            end
            if ((hold_q == HOLD_MAX) && !long_done_q) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end
        end else begin
            hold_d      = '0;
            long_done_d = 1'b0;
        end

        // Long press clears the LED and wins over a toggle.
        if (long_d) begin
            led_d = 1'b0;
        end else if (press_d) begin
            led_d = ~led_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            cnt_q         <= '0;
            hold_q        <= '0;
            long_done_q   <= 1'b0;
            key_level_q   <= 1'b0;
            press_q       <= 1'b0;
            rel_q         <= 1'b0;
            long_q        <= 1'b0;
            led_q         <= LED_INIT;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            long_done_q   <= long_done_d;
            key_level_q   <= key_level_d;
            press_q       <= press_d;
            rel_q         <= rel_d;
            long_q        <= long_d;
            led_q         <= led_d;
        end
    end

    assign key_level   = key_level_q;
    assign press_pulse = press_q;
    assign rel_pulse   = rel_q;
    assign long_pulse  = long_q;
    assign led         = led_q;

endmodule : key_debounce_ch

// File: rtl/key_debounce_bank.sv
// Bank of independent key channels; the top only fans buses out and in.
module key_debounce_bank
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS       = 3,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_20MS_50M,
    parameter int unsigned LONG_CYC     = LONG_1S_50M,
    parameter logic        LED_INIT     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] rel_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] led
);

    // One channel instance per key.
    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .LED_INIT     (LED_INIT)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .press_pulse (press_pulse[i]),
            .rel_pulse   (rel_pulse[i]),
            .long_pulse  (long_pulse[i]),
            .led         (led[i])
        );
    end

endmodule : key_debounce_bank

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank (N_KEYS=3, DEBOUNCE_CYC=4, LONG_CYC=10).
module tb_key_debounce_bank;

    logic       clk;
    logic       rst;
    logic [2:0] key_n;
    logic [2:0] key_level;
    logic [2:0] press_pulse;
    logic [2:0] rel_pulse;
    logic [2:0] long_pulse;
    logic [2:0] led;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  key_n;
        int          cyc;
        logic [2:0]  lvl;
        logic [2:0]  prs;
        logic [2:0]  rel;
        logic [2:0]  lng;
        logic [2:0]  led;
    } vec_t;

    vec_t tbl[$];

    key_debounce_bank #(
        .N_KEYS       (3),
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (10),
        .LED_INIT     (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .press_pulse (press_pulse),
        .rel_pulse   (rel_pulse),
        .long_pulse  (long_pulse),
        .led         (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic r, logic [2:0] k, int c, logic [2:0] lv,
                                logic [2:0] pr, logic [2:0] rl, logic [2:0] lg,
                                logic [2:0] ld);
        vec_t v;
        v.rst = r; v.key_n = k; v.cyc = c; v.lvl = lv;
        v.prs = pr; v.rel = rl; v.lng = lg; v.led = ld;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [2:0] act, logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic expect5(string tag, logic [2:0] lv, logic [2:0] pr,
                           logic [2:0] rl, logic [2:0] lg, logic [2:0] ld);
        chk({tag, " key_level"},   key_level,   lv);
        chk({tag, " press_pulse"}, press_pulse, pr);
        chk({tag, " rel_pulse"},   rel_pulse,   rl);
        chk({tag, " long_pulse"},  long_pulse,  lg);
        chk({tag, " led"},         led,         ld);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        key_n = 3'b111;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 3'b010;

        // Reset, clean press/release of key0, concurrent key0+key2, second key0 press.
        tbl.push_back(mk(1'b1, 3'b010,  3, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(1'b0, 3'b111, 50, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(1'b0, 3'b110,  6, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(1'b0, 3'b110,  1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001));
        tbl.push_back(mk(1'b0, 3'b110,  1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001));
        tbl.push_back(mk(1'b0, 3'b111,  6, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001));
        tbl.push_back(mk(1'b0, 3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001));
        tbl.push_back(mk(1'b0, 3'b111, 10, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001));
        tbl.push_back(mk(1'b1, 3'b111,  2, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(1'b0, 3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(1'b0, 3'b010,  6, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(1'b0, 3'b010,  1, 3'b101, 3'b101, 3'b000, 3'b000, 3'b101));
        tbl.push_back(mk(1'b0, 3'b010,  1, 3'b101, 3'b000, 3'b000, 3'b000, 3'b101));
        tbl.push_back(mk(1'b0, 3'b111,  6, 3'b101, 3'b000, 3'b000, 3'b000, 3'b101));
        tbl.push_back(mk(1'b0, 3'b111,  1, 3'b000, 3'b000, 3'b101, 3'b000, 3'b101));
        tbl.push_back(mk(1'b0, 3'b111,  4, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101));
        tbl.push_back(mk(1'b0, 3'b110,  6, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101));
        tbl.push_back(mk(1'b0, 3'b110,  1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b100));
        tbl.push_back(mk(1'b0, 3'b111,  6, 3'b001, 3'b000, 3'b000, 3'b000, 3'b100));
        tbl.push_back(mk(1'b0, 3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b000, 3'b100));
        tbl.push_back(mk(1'b0, 3'b111,  4, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100));

        foreach (tbl[i]) begin
            rst   = tbl[i].rst;
            key_n = tbl[i].key_n;
            for (int c = 0; c < tbl[i].cyc; c++) begin
                tick();
                expect5($sformatf("vec%0d.%0d", i, c), tbl[i].lvl, tbl[i].prs,
                        tbl[i].rel, tbl[i].lng, tbl[i].led);
            end
        end

        // Bounce on key0 every 2 cycles, then settle pressed.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            key_n = {2'b11, 1'(((k / 2) % 2))};
            tick();
            expect5($sformatf("bounce%0d", k), 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        key_n = 3'b110;
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect5($sformatf("settle%0d", e), (e >= 7) ? 3'b001 : 3'b000,
                    (e == 7) ? 3'b001 : 3'b000, 3'b000, 3'b000,
                    (e >= 7) ? 3'b001 : 3'b000);
        end
        key_n = 3'b111;
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect5($sformatf("bnc_rel%0d", e), (e < 7) ? 3'b001 : 3'b000, 3'b000,
                    (e == 7) ? 3'b001 : 3'b000, 3'b000, 3'b001);
        end

        // Long press on key1: held 20 cycles.
        do_reset();
        key_n = 3'b101;
        for (int e = 1; e <= 30; e++) begin
            if (e == 21) key_n = 3'b111;
            tick();
            expect5($sformatf("long%0d", e),
                    (e >= 7 && e < 27) ? 3'b010 : 3'b000,
                    (e == 7)  ? 3'b010 : 3'b000,
                    (e == 27) ? 3'b010 : 3'b000,
                    (e == 16) ? 3'b010 : 3'b000,
                    (e >= 7 && e < 16) ? 3'b010 : 3'b000);
        end

        // Short 5-cycle press on key1: press and release only.
        key_n = 3'b101;
        for (int e = 1; e <= 20; e++) begin
            if (e == 6) key_n = 3'b111;
            tick();
            expect5($sformatf("short%0d", e),
                    (e >= 7 && e < 12) ? 3'b010 : 3'b000,
                    (e == 7)  ? 3'b010 : 3'b000,
                    (e == 12) ? 3'b010 : 3'b000,
                    3'b000,
                    (e >= 7) ? 3'b010 : 3'b000);
        end

        // Reset while key2 is held with hold_cnt at 5, key still held afterwards.
        do_reset();
        key_n = 3'b011;
        for (int e = 1; e <= 11; e++) begin
            tick();
            expect5($sformatf("hold%0d", e), (e >= 7) ? 3'b100 : 3'b000,
                    (e == 7) ? 3'b100 : 3'b000, 3'b000, 3'b000,
                    (e >= 7) ? 3'b100 : 3'b000);
        end
        rst = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            expect5($sformatf("midrst%0d", e), 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect5($sformatf("repress%0d", e), (e >= 7) ? 3'b100 : 3'b000,
                    (e == 7) ? 3'b100 : 3'b000, 3'b000, 3'b000,
                    (e >= 7) ? 3'b100 : 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_key_debounce_bank
